tdm_demux: RTL and testbench

- 1-to-NCH time-division demultiplexer. Receives a word-serial TDM stream (one word per slot, frame marker on slot 0) and routes each word to a per-channel holding register.
- Acts as the receive-side counterpart of the team's 4:1 select muxes: a TDM framer muxes channels onto one stream, and this block recovers them.
- Contains a frame-sync state machine, slot counter, per-channel valid pulses and alignment-error accounting.

---
 rtl/tdm_demux.sv | 140 ++++++++++++++
 tb/tb_tdm_demux.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// 1-to-NCH TDM demultiplexer: frame-sync FSM, slot counter, per-channel holding registers.
// Optional parity checking on incoming words is enabled with TDM_DEMUX_PARITY_EN.
module tdm_demux #(
    parameter int WIDTH     = 8,
    parameter int NCH       = 4,
    parameter int SYNC_MISS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sof,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic                   in_parity,
    output logic                   parity_err,
`endif
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic [NCH-1:0]         out_valid,
    output logic                   frame_done,
    output logic                   locked,
    output logic [7:0]             err_cnt
);

    localparam int SW = $clog2(NCH);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] slot, slot_nx;
    logic [2:0]    miss, miss_nx;
    logic          wr;
    logic [SW-1:0] wr_ch;
    logic          fd_nx;
    logic          err_inc;
    logic          bad;
    logic          wr_ok;

`ifdef TDM_DEMUX_PARITY_EN
    // in_parity makes the total number of ones even, so it must equal the data's XOR.
    assign bad = in_parity != (^in_data);
`else
    assign bad = 1'b0;
`endif

    // A bad-parity word still advances the slot/sync machinery; only its write is dropped.
    assign wr_ok = wr & ~bad;

    always_comb begin
        state_nx = state;
        slot_nx  = slot;
        miss_nx  = miss;
        wr       = 1'b0;
        wr_ch    = '0;
        fd_nx    = 1'b0;
        err_inc  = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_sof) begin
                        wr       = 1'b1;
                        slot_nx  = SLOT_ONE;
                        miss_nx  = '0;
                        state_nx = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot == '0) begin
                        if (in_sof) begin
                            wr      = 1'b1;
                            slot_nx = SLOT_ONE;
                            miss_nx = '0;
                        end else begin
                            // Missing marker: tolerate up to SYNC_MISS-1 in a row, then drop lock.
                            err_inc = 1'b1;
                            if (int'(miss) + 1 >= SYNC_MISS) begin
                                state_nx = HUNT;
                                slot_nx  = '0;
                                miss_nx  = '0;
                            end else begin
                                wr      = 1'b1;
                                slot_nx = SLOT_ONE;
                                miss_nx = miss + 3'd1;
                            end
                        end
                    end else if (in_sof) begin
                        wr      = 1'b1;
                        slot_nx = SLOT_ONE;
                        miss_nx = '0;
                        err_inc = 1'b1;
                    end else begin
                        wr      = 1'b1;
                        wr_ch   = slot;
                        slot_nx = slot + SLOT_ONE;
                        fd_nx   = (slot == LAST_SLOT);
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= '0;
            miss       <= '0;
            out_data   <= '0;
            out_valid  <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= '0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            slot       <= slot_nx;
            miss       <= miss_nx;
            out_valid  <= '0;
            frame_done <= fd_nx;
            locked     <= (state_nx == LOCKED);
            if (wr_ok) begin
                out_data[int'(wr_ch)*WIDTH +: WIDTH] <= in_data;
                out_valid[wr_ch]                     <= 1'b1;
            end
            if (err_inc && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= wr & bad;
`endif
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: a behavioural model queues the expected outputs per cycle.
// Covers the parity scenario too when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux;

    localparam int WIDTH     = 8;
    localparam int NCH       = 4;
    localparam int SYNC_MISS = 2;
    localparam int OW        = NCH*WIDTH + NCH + 1 + 1 + 8 + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_sof;
    logic                 in_parity;
    logic                 parity_err_w;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_valid;
    logic                 frame_done;
    logic                 locked;
    logic [7:0]           err_cnt;

    int checks   = 0;
    int failures = 0;

    logic [OW-1:0] sb[$];

    // Reference model state
    bit                   m_lk;
    int                   m_slot;
    int                   m_miss;
    int                   m_err;
    logic [NCH*WIDTH-1:0] m_data;

    always #5 clk = ~clk;

    tdm_demux #(.WIDTH(WIDTH), .NCH(NCH), .SYNC_MISS(SYNC_MISS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sof     (in_sof),
`ifdef TDM_DEMUX_PARITY_EN
        .in_parity  (in_parity),
        .parity_err (parity_err_w),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .err_cnt    (err_cnt)
    );

`ifndef TDM_DEMUX_PARITY_EN
    assign parity_err_w = 1'b0;
`endif

    function automatic logic [OW-1:0] observed();
        return {out_data, out_valid, frame_done, locked, err_cnt, parity_err_w};
    endfunction

    // Drives one cycle, advances the model and queues what the DUT should show after the edge.
    task automatic drive(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit s, input bit pgood);
        logic [NCH-1:0] ev;
        bit             efd, epe, w;
        int             ch;
        @(negedge clk);
        rst_n     = r;
        in_valid  = v;
        in_data   = d;
        in_sof    = s;
        in_parity = (^d) ^ !pgood;
        ev = '0; efd = 0; epe = 0; w = 0; ch = 0;
        if (!r) begin
            m_lk = 0; m_slot = 0; m_miss = 0; m_err = 0; m_data = '0;
        end else if (v) begin
            if (!m_lk) begin
                if (s) begin
                    m_lk = 1; w = 1; m_slot = 1; m_miss = 0;
                end
            end else if (m_slot == 0 && s) begin
                w = 1; m_slot = 1; m_miss = 0;
            end else if (m_slot != 0 && !s) begin
                w = 1; ch = m_slot;
                efd = (m_slot == NCH - 1);
                m_slot = (m_slot + 1) % NCH;
            end else if (s) begin
                w = 1; m_slot = 1; m_miss = 0;
                m_err = (m_err < 255) ? m_err + 1 : 255;
            end else begin
                m_miss++;
                m_err = (m_err < 255) ? m_err + 1 : 255;
                if (m_miss < SYNC_MISS) begin
                    w = 1; m_slot = 1;
                end else begin
                    m_lk = 0; m_slot = 0; m_miss = 0;
                end
            end
`ifdef TDM_DEMUX_PARITY_EN
            if (w && !pgood) begin
                epe = 1; w = 0;
            end
`endif
            if (w) begin
                m_data[ch*WIDTH +: WIDTH] = d;
                ev[ch] = 1'b1;
            end
        end
        sb.push_back({m_data, ev, efd, m_lk, 8'(m_err), epe});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] e;
        for (int i = 0; i < 7; i++) begin
            drive(i >= 2, 0, 8'h00, 0, 1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("[TB] FAIL reset_idle[%0d] got=%h want=%h", i, observed(), e);
            end
        end
    endtask

    task automatic test_lock_frame();
        logic [OW-1:0]  e;
        logic [WIDTH-1:0] d[5] = '{8'h11, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        bit             s[5] = '{0, 1, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, d[i], s[i], 1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("[TB] FAIL lock_frame[%0d] got=%h want=%h", i, observed(), e);
            end
        end
        checks++;
        if (out_data !== 32'hA3A2A1A0) begin
            failures++;
            $display("[TB] FAIL lock_frame_data got=%h want=a3a2a1a0", out_data);
        end
    endtask

    task automatic test_gapped();
        logic [OW-1:0] e;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) drive(1, 1, 8'h50 + 8'(i / 4), i == 0, 1);
            else            drive(1, 0, 8'hEE, 1, 1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("[TB] FAIL gapped[%0d] got=%h want=%h", i, observed(), e);
            end
        end
        checks++;
        if (out_data !== 32'h53525150) begin
            failures++;
            $display("[TB] FAIL gapped_data got=%h want=53525150", out_data);
        end
    endtask

    task automatic test_early_marker();
        logic [OW-1:0]    e;
        logic [WIDTH-1:0] d[6] = '{8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
        bit               s[6] = '{1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, d[i], s[i], 1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("[TB] FAIL early_marker[%0d] got=%h want=%h", i, observed(), e);
            end
            if (i == 2) begin
                checks++;
                if (err_cnt !== 8'd1 || frame_done !== 1'b0 || out_valid !== 4'b0001) begin
                    failures++;
                    $display("[TB] FAIL early_marker_realign err=%0d fd=%b ov=%b want err=1 fd=0 ov=0001",
                             err_cnt, frame_done, out_valid);
                end
            end
        end
    endtask

    task automatic test_loss_of_lock();
        logic [OW-1:0] e;
        for (int i = 0; i < 10; i++) begin
            // Slot-0 words of the first two frames carry no marker; the last word relocks.
            drive(1, 1, 8'hD0 + 8'(i), i == 9, 1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("[TB] FAIL loss_of_lock[%0d] got=%h want=%h", i, observed(), e);
            end
            if (i == 4) begin
                checks++;
                if (locked !== 1'b0 || out_valid !== 4'b0000 || err_cnt !== 8'd3) begin
                    failures++;
                    $display("[TB] FAIL loss_of_lock_drop lk=%b ov=%b err=%0d want lk=0 ov=0000 err=3",
                             locked, out_valid, err_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [OW-1:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(i != 2, i != 3, 8'hE0 + 8'(i), i == 0, 1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("[TB] FAIL reset_mid_frame[%0d] got=%h want=%h", i, observed(), e);
            end
        end
        checks++;
        if (out_data !== '0 || locked !== 1'b0 || err_cnt !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_frame_clear data=%h lk=%b err=%0d want all 0", out_data, locked, err_cnt);
        end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        logic [OW-1:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'h70 + 8'(i), i == 0, i != 2);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("[TB] FAIL parity[%0d] got=%h want=%h", i, observed(), e);
            end
            if (i == 2) begin
                checks++;
                if (parity_err_w !== 1'b1 || out_valid !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL parity_bad_word pe=%b ov=%b want pe=1 ov=0000", parity_err_w, out_valid);
                end
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL parity_frame_done got=%b want=1", frame_done);
        end
    endtask
`endif

    task automatic test_err_saturate();
        logic [OW-1:0] e;
        // Every marker after the first arrives on slot 1, so each one is an early-marker error.
        for (int i = 0; i < 262; i++) begin
            drive(1, 1, 8'(i), 1, 1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("[TB] FAIL err_saturate[%0d] got=%h want=%h", i, observed(), e);
            end
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            failures++;
            $display("[TB] FAIL err_saturate_final got=%0d want=255", err_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0; in_parity = 1'b0;
        m_lk = 0; m_slot = 0; m_miss = 0; m_err = 0; m_data = '0;
        test_reset();
        test_lock_frame();
        test_gapped();
        test_early_marker();
        test_loss_of_lock();
        test_reset_mid_frame();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_err_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
